// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the
// string transmitter and its byte serializer.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_BAUD_DIV_DEF = 10416;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } uart_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with registered tx.
// A load in the last stop cycle chains the next frame with no gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          baud_end;
  logic [2:0]    bit_nxt;

  assign baud_end = (baud_q == BW'(BAUD_DIV - 1));
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    data_d      = data_q;
    tx_d        = tx_q;
    byte_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load_i) begin
          state_d = START;
          data_d  = byte_i;
          tx_d    = 1'b0;
          baud_d  = '0;
        end
      end
      START: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = data_q[bit_nxt];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_end) begin
          baud_d      = '0;
          byte_done_o = 1'b1;
          if (load_i) begin
            state_d = START;
            data_d  = byte_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/uart_str_tx.sv
// Sends a MSG_LEN-byte string, byte 0 first, per start pulse.
// Remaining bytes sit in a shift-down shadow register.
module uart_str_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEF,
  parameter int MSG_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*MSG_LEN-1:0] msg,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(MSG_LEN + 1);

  uart_state_e st_q, st_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [8*MSG_LEN-1:0] shadow_q, shadow_d;
  logic                 load;
  logic [7:0]           ld_byte;
  logic                 byte_done;

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .byte_i      (ld_byte),
    .tx_o        (tx),
    .byte_done_o (byte_done)
  );

  // Top level only uses IDLE, DATA (sending) and DONE.
  always_comb begin
    st_d     = st_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    ld_byte  = shadow_q[7:0];
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d     = DATA;
          load     = 1'b1;
          ld_byte  = msg[7:0];
          shadow_d = msg >> 8;
          idx_d    = IW'(1);
        end
      end
      DATA: begin
        if (byte_done) begin
          if (idx_q == IW'(MSG_LEN)) begin
            st_d  = DONE;
            idx_d = '0;
          end else begin
            load     = 1'b1;
            shadow_d = shadow_q >> 8;
            idx_d    = idx_q + IW'(1);
          end
        end
      end
      DONE: st_d = IDLE;
      default: begin
        st_d  = IDLE;
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  assign busy = (st_q == DATA);
  assign done = (st_q == DONE);

endmodule

// File: tb/tb_uart_str_tx.sv
// Bench for uart_str_tx: 3-byte and 1-byte instances at BAUD_DIV=4,
// compared cycle by cycle against an arithmetic frame model.
module tb_uart_str_tx;

  localparam int B  = 4;
  localparam int L  = 3;
  localparam int FB = 10 * B;
  localparam int ML = L * FB;
  localparam int P  = ML + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start1;
  logic [23:0] msg;
  logic [7:0]  msg1;
  logic        tx, busy, done;
  logic        tx1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_str_tx #(.BAUD_DIV(B), .MSG_LEN(L)) u_dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_str_tx #(.BAUD_DIV(B), .MSG_LEN(1)) u_one (
    .clk(clk), .rst(rst), .start(start1), .msg(msg1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  // k = cycles since the first start-bit cycle.
  function automatic logic exp_tx(input logic [23:0] m,
                                  input int len, input int k);
    int f, p;
    logic [23:0] s;
    if (k < 0) return 1'b1;
    f = k / FB;
    p = (k % FB) / B;
    if (f >= len) return 1'b1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    s = m >> (8 * f + p - 1);
    return s[0];
  endfunction

  task automatic test_reset();
    int w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_dut tx/busy/done=%b exp 100", {tx, busy, done});
    end
    checks++;
    if ({tx1, busy1, done1} !== 3'b100) begin
      errors++;
      $display("FAIL reset_one tx/busy/done=%b exp 100", {tx1, busy1, done1});
    end
    rst = 1'b0;
    @(negedge clk);
    msg = 24'($urandom);
    msg1 = 8'($urandom);
    start = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start1 = 1'b0;
    w = $urandom_range(3, 100);
    repeat (w) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset_dut w=%0d got %b exp 100", w, {tx, busy, done});
    end
    checks++;
    if ({tx1, busy1, done1} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset_one w=%0d got %b exp 100", w, {tx1, busy1, done1});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done, tx1, busy1, done1} !== 6'b100100) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d got %b exp 100100", k,
                 {tx, busy, done, tx1, busy1, done1});
      end
    end
  endtask

  task automatic test_single();
    logic et, eb, ed;
    msg1 = 8'hA5;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k <= FB + 1; k++) begin
      et = exp_tx({16'h0, 8'hA5}, 1, k);
      eb = (k < FB);
      ed = (k == FB);
      checks++;
      if ({tx1, busy1, done1} !== {et, eb, ed}) begin
        errors++;
        $display("FAIL single k=%0d tx/busy/done=%b exp %b", k,
                 {tx1, busy1, done1}, {et, eb, ed});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_multi();
    logic et, eb, ed;
    logic [7:0] dec [L];
    logic [23:0] m;
    int r;
    m = 24'h434241;
    msg = m;
    for (int i = 0; i < L; i++) dec[i] = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= ML + 1; k++) begin
      et = exp_tx(m, L, k);
      eb = (k < ML);
      ed = (k == ML);
      checks++;
      if ({tx, busy, done} !== {et, eb, ed}) begin
        errors++;
        $display("FAIL multi k=%0d tx/busy/done=%b exp %b", k,
                 {tx, busy, done}, {et, eb, ed});
      end
      r = k % FB;
      if (k < ML && r >= B && r < 9 * B && (r % B) == B / 2)
        dec[k / FB][r / B - 1] = tx;
      @(negedge clk);
    end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (dec[i] !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL multi_decode byte%0d got %h exp %h", i, dec[i], 8'(8'h41 + i));
      end
    end
  endtask

  task automatic test_start_busy();
    logic et, eb, ed;
    logic [23:0] m;
    int inj, nd;
    m = 24'($urandom);
    msg = m;
    inj = $urandom_range(5, ML - 5);
    nd = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= ML + 40; k++) begin
      et = exp_tx(m, L, k);
      eb = (k < ML);
      ed = (k == ML);
      if (done) nd++;
      checks++;
      if ({tx, busy, done} !== {et, eb, ed}) begin
        errors++;
        $display("FAIL start_busy k=%0d inj=%0d tx/busy/done=%b exp %b", k, inj,
                 {tx, busy, done}, {et, eb, ed});
      end
      start = (k == inj);
      @(negedge clk);
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL start_busy_done_count got %0d exp 1", nd);
    end
  endtask

  task automatic test_msg_change();
    logic et, eb, ed;
    logic [23:0] m;
    int chg;
    m = 24'($urandom);
    msg = m;
    chg = $urandom_range(1, ML - 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= ML + 1; k++) begin
      et = exp_tx(m, L, k);
      eb = (k < ML);
      ed = (k == ML);
      checks++;
      if ({tx, busy, done} !== {et, eb, ed}) begin
        errors++;
        $display("FAIL msg_change k=%0d chg=%0d tx/busy/done=%b exp %b", k, chg,
                 {tx, busy, done}, {et, eb, ed});
      end
      if (k == chg) msg = ~m ^ 24'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic et, eb, ed;
    logic [23:0] m;
    int o;
    m = 24'($urandom);
    msg = m;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3 * P + 20; k++) begin
      o = k % P;
      if (k < 3 * P) begin
        et = exp_tx(m, L, o);
        eb = (o < ML);
        ed = (o == ML);
      end else begin
        et = 1'b1;
        eb = 1'b0;
        ed = 1'b0;
      end
      checks++;
      if ({tx, busy, done} !== {et, eb, ed} || (busy && done)) begin
        errors++;
        $display("FAIL back_to_back k=%0d tx/busy/done=%b exp %b", k,
                 {tx, busy, done}, {et, eb, ed});
      end
      if (k == 3 * P - 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    msg = '0;
    msg1 = '0;
    test_reset();
    repeat (3) @(negedge clk);
    test_single();
    repeat (3) @(negedge clk);
    test_multi();
    repeat (3) @(negedge clk);
    test_start_busy();
    repeat (3) @(negedge clk);
    test_msg_change();
    repeat (3) @(negedge clk);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
